// File: rtl/rvm_alu_sequencer_pkg.sv
// Shared constants and types for the RV32I OP/OP-IMM ALU sequencer.
// Contents: opcode/funct3/funct7 values, functional-unit op codes,
// FU-select and FSM state encodings, the decoded-instruction record
// and an immediate sign-extension helper.
package rvm_alu_sequencer_pkg;

    // Major opcodes handled by the sequencer
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // funct3 values
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct7 values: base encoding and the SUB/SRA alternate
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Functional-unit op codes
    localparam logic [1:0] ADD_OP_ADD = 2'b00;
    localparam logic [1:0] ADD_OP_SUB = 2'b01;
    localparam logic [1:0] BIT_OP_AND = 2'b00;
    localparam logic [1:0] BIT_OP_OR  = 2'b01;
    localparam logic [1:0] BIT_OP_XOR = 2'b10;
    localparam logic [1:0] SHF_OP_SLL = 2'b00;
    localparam logic [1:0] SHF_OP_SRL = 2'b01;
    localparam logic [1:0] SHF_OP_SRA = 2'b10;

    typedef enum logic [1:0] {
        FU_NONE = 2'b00,
        FU_ADD  = 2'b01,
        FU_BIT  = 2'b10,
        FU_SHF  = 2'b11
    } fu_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_OPND  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WB    = 3'd4,
        ST_FAULT = 3'd5,
        ST_ERR   = 3'd6
    } state_e;

    typedef struct packed {
        fu_sel_e     fu_sel;
        logic [1:0]  op;
        logic        use_imm;    // rhs comes from the immediate
        logic [31:0] imm;        // already sign- or zero-extended
        logic        rs2_used;   // OP form reads rs2
        logic        shift_reg;  // register shift: only rs2[4:0] is used
        logic        slt;
        logic        sltu;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        illegal;
    } dec_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/rvm_alu_sequencer_decode.sv
// Combinational decoder for RV32I OP / OP-IMM instructions.
// Ports:
//   instr : 32-bit instruction word
//   dec   : decoded record (FU select, op, operand select, SLT flags,
//           register addresses, illegal flag)
module rvm_alu_sequencer_decode
    import rvm_alu_sequencer_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    logic       is_op_s;
    logic       is_imm_s;
    logic       f7_base_s;
    logic       f7_alt_s;
    logic       f7_ok_s;
    logic       is_shift_s;

    // Instruction field decode and legality check
    always_comb begin
        opcode_s   = instr[6:0];
        funct3_s   = instr[14:12];
        funct7_s   = instr[31:25];
        is_op_s    = (opcode_s == OPC_OP);
        is_imm_s   = (opcode_s == OPC_OP_IMM);
        f7_base_s  = (funct7_s == F7_BASE);
        f7_alt_s   = (funct7_s == F7_ALT);
        f7_ok_s    = 1'b0;
        is_shift_s = 1'b0;
        dec        = '0;
        dec.fu_sel = FU_NONE;

        // For non-shift OP-IMM forms the funct7 field is immediate bits,
        // so only OP and the shift-immediates constrain it.
        case (funct3_s)
            F3_ADD: begin
                dec.fu_sel = FU_ADD;
                if (is_op_s && f7_alt_s) begin
                    dec.op = ADD_OP_SUB;
                end else begin
                    dec.op = ADD_OP_ADD;
                end
                f7_ok_s = is_imm_s || f7_base_s || f7_alt_s;
            end
            F3_SLL: begin
                dec.fu_sel = FU_SHF;
                dec.op     = SHF_OP_SLL;
                is_shift_s = 1'b1;
                f7_ok_s    = f7_base_s;
            end
            F3_SLT: begin
                dec.fu_sel = FU_ADD;
                dec.op     = ADD_OP_SUB;
                dec.slt    = 1'b1;
                f7_ok_s    = is_imm_s || f7_base_s;
            end
            F3_SLTU: begin
                dec.fu_sel = FU_ADD;
                dec.op     = ADD_OP_SUB;
                dec.sltu   = 1'b1;
                f7_ok_s    = is_imm_s || f7_base_s;
            end
            F3_XOR: begin
                dec.fu_sel = FU_BIT;
                dec.op     = BIT_OP_XOR;
                f7_ok_s    = is_imm_s || f7_base_s;
            end
            F3_OR: begin
                dec.fu_sel = FU_BIT;
                dec.op     = BIT_OP_OR;
                f7_ok_s    = is_imm_s || f7_base_s;
            end
            F3_AND: begin
                dec.fu_sel = FU_BIT;
                dec.op     = BIT_OP_AND;
                f7_ok_s    = is_imm_s || f7_base_s;
            end
            F3_SR: begin
                dec.fu_sel = FU_SHF;
                if (f7_alt_s) begin
                    dec.op = SHF_OP_SRA;
                end else begin
                    dec.op = SHF_OP_SRL;
                end
                is_shift_s = 1'b1;
                f7_ok_s    = f7_base_s || f7_alt_s;
            end
            default: begin
                f7_ok_s = 1'b0;
            end
        endcase

        dec.illegal = !(is_op_s || is_imm_s) || !f7_ok_s;

        if (dec.illegal) begin
            dec.fu_sel = FU_NONE;
            dec.op     = 2'b00;
            dec.slt    = 1'b0;
            dec.sltu   = 1'b0;
        end else begin
            dec.use_imm   = is_imm_s;
            dec.rs2_used  = is_op_s;
            dec.shift_reg = is_op_s && is_shift_s;
        end

        if (is_shift_s) begin
            dec.imm = {27'd0, instr[24:20]};
        end else begin
            dec.imm = sext12(instr[31:20]);
        end

        dec.rd  = instr[11:7];
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
    end

endmodule

// File: rtl/rvm_alu_sequencer.sv
// Multi-cycle sequencer for RV32I OP / OP-IMM instructions.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   instr_valid/instr/instr_ready : instruction handshake from fetch
//   done/illegal/fu_error      : one-cycle completion status pulses
//   rs1_*/rs2_*                : GPR read ports (data valid cycle after enable)
//   rd_*                       : GPR write port
//   add_*/bit_*/shf_*          : adder, bitwise and shift functional units
module rvm_alu_sequencer
    import rvm_alu_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic            done,
    output logic            illegal,
    output logic            fu_error,
    output logic            rs1_en,
    output logic            rs2_en,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_rdata,
    input  logic [XLEN-1:0] rs2_rdata,
    output logic            rd_wen,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_wdata,
    output logic [XLEN-1:0] add_lhs,
    output logic [XLEN-1:0] add_rhs,
    output logic [1:0]      add_op,
    input  logic            add_valid,
    input  logic [XLEN:0]   add_result,
    output logic [XLEN-1:0] bit_lhs,
    output logic [XLEN-1:0] bit_rhs,
    output logic [1:0]      bit_op,
    input  logic            bit_valid,
    input  logic [XLEN-1:0] bit_result,
    output logic [XLEN-1:0] shf_lhs,
    output logic [XLEN-1:0] shf_rhs,
    output logic [1:0]      shf_op,
    input  logic            shf_valid,
    input  logic [XLEN-1:0] shf_result
);

    state_e          state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] lhs_q, lhs_d;
    logic [XLEN-1:0] rhs_q, rhs_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic [XLEN-1:0] rd_wdata_q, rd_wdata_d;

    logic [31:0]     dec_instr_s;
    dec_t            dec_s;
    logic            fu_valid_s;
    logic [XLEN-1:0] fu_result_s;
    logic            slt_bit_s;

    // In IDLE decode the offered word; afterwards the latched one
    always_comb begin
        if (state_q == ST_IDLE) begin
            dec_instr_s = instr;
        end else begin
            dec_instr_s = instr_q;
        end
    end

    rvm_alu_sequencer_decode u_decode (
        .instr (dec_instr_s),
        .dec   (dec_s)
    );

    // Select the valid/result of the FU chosen by the decoder
    always_comb begin
        // Signed compare: differing signs decide directly, else the
        // sign of the difference cannot overflow.
        if (lhs_q[XLEN-1] ^ rhs_q[XLEN-1]) begin
            slt_bit_s = lhs_q[XLEN-1];
        end else begin
            slt_bit_s = add_result[XLEN-1];
        end
        case (dec_s.fu_sel)
            FU_ADD: begin
                fu_valid_s = add_valid;
                if (dec_s.slt) begin
                    fu_result_s = {{(XLEN-1){1'b0}}, slt_bit_s};
                end else if (dec_s.sltu) begin
                    fu_result_s = {{(XLEN-1){1'b0}}, add_result[XLEN]};
                end else begin
                    fu_result_s = add_result[XLEN-1:0];
                end
            end
            FU_BIT: begin
                fu_valid_s  = bit_valid;
                fu_result_s = bit_result;
            end
            FU_SHF: begin
                fu_valid_s  = shf_valid;
                fu_result_s = shf_result;
            end
            default: begin
                fu_valid_s  = 1'b0;
                fu_result_s = '0;
            end
        endcase
    end

    // Next-state and datapath register logic
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        lhs_d      = lhs_q;
        rhs_d      = rhs_q;
        cnt_d      = cnt_q;
        rd_addr_d  = 5'd0;
        rd_wdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    if (dec_s.illegal) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                state_d = ST_OPND;
            end
            ST_OPND: begin
                lhs_d = rs1_rdata;
                if (dec_s.use_imm) begin
                    rhs_d = dec_s.imm;
                end else if (dec_s.shift_reg) begin
                    rhs_d = {{(XLEN-5){1'b0}}, rs2_rdata[4:0]};
                end else begin
                    rhs_d = rs2_rdata;
                end
                cnt_d   = 4'd0;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                cnt_d = cnt_q + 4'd1;
                if (fu_valid_s) begin
                    rd_addr_d  = dec_s.rd;
                    rd_wdata_d = fu_result_s;
                    state_d    = ST_WB;
                end else if (cnt_q == 4'd14) begin
                    // This is the 15th EXEC cycle without a valid
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_WB:    state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            instr_q    <= 32'd0;
            lhs_q      <= '0;
            rhs_q      <= '0;
            cnt_q      <= 4'd0;
            rd_addr_q  <= 5'd0;
            rd_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            lhs_q      <= lhs_d;
            rhs_q      <= rhs_d;
            cnt_q      <= cnt_d;
            rd_addr_q  <= rd_addr_d;
            rd_wdata_q <= rd_wdata_d;
        end
    end

    assign rd_addr  = rd_addr_q;
    assign rd_wdata = rd_wdata_q;

    // Output decode from the state register
    always_comb begin
        instr_ready = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        fu_error    = 1'b0;
        rs1_en      = 1'b0;
        rs2_en      = 1'b0;
        rs1_addr    = 5'd0;
        rs2_addr    = 5'd0;
        rd_wen      = 1'b0;
        add_lhs     = '0;
        add_rhs     = '0;
        add_op      = 2'b00;
        bit_lhs     = '0;
        bit_rhs     = '0;
        bit_op      = 2'b00;
        shf_lhs     = '0;
        shf_rhs     = '0;
        shf_op      = 2'b00;
        case (state_q)
            ST_IDLE: instr_ready = 1'b1;
            ST_READ: begin
                rs1_en   = 1'b1;
                rs1_addr = dec_s.rs1;
                if (dec_s.rs2_used) begin
                    rs2_en   = 1'b1;
                    rs2_addr = dec_s.rs2;
                end else begin
                    rs2_en   = 1'b0;
                    rs2_addr = 5'd0;
                end
            end
            ST_EXEC: begin
                case (dec_s.fu_sel)
                    FU_ADD: begin
                        add_lhs = lhs_q;
                        add_rhs = rhs_q;
                        add_op  = dec_s.op;
                    end
                    FU_BIT: begin
                        bit_lhs = lhs_q;
                        bit_rhs = rhs_q;
                        bit_op  = dec_s.op;
                    end
                    FU_SHF: begin
                        shf_lhs = lhs_q;
                        shf_rhs = rhs_q;
                        shf_op  = dec_s.op;
                    end
                    default: add_op = 2'b00;
                endcase
            end
            ST_WB: begin
                done   = 1'b1;
                rd_wen = (rd_addr_q != 5'd0);
            end
            ST_FAULT: illegal  = 1'b1;
            ST_ERR:   fu_error = 1'b1;
            default:  instr_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_rvm_alu_sequencer.sv
// Directed self-checking bench for rvm_alu_sequencer with a GPR model
// (one-cycle read latency) and combinational FU models whose valids the
// bench can hold low.
module tb_rvm_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready, done, illegal, fu_error;
    logic        rs1_en, rs2_en;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_rdata, rs2_rdata;
    logic        rd_wen;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] add_lhs, add_rhs, bit_lhs, bit_rhs, shf_lhs, shf_rhs;
    logic [1:0]  add_op, bit_op, shf_op;
    logic        add_valid, bit_valid, shf_valid;
    logic [32:0] add_result;
    logic [31:0] bit_result, shf_result;
    logic        add_ven, bit_ven, shf_ven;
    logic [31:0] gpr [32];

    int checks = 0;
    int fails  = 0;

    // Captured observations of the last instruction
    int          cyc_done, cyc_ill, cyc_err, cyc_ready, wen_cnt;
    logic        rs1_seen, c1_rs1_en, c1_rs2_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] cap_add_lhs, cap_add_rhs, cap_bit_lhs, cap_shf_lhs, cap_shf_rhs;
    logic [1:0]  cap_add_op, cap_bit_op, cap_shf_op;

    rvm_alu_sequencer dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .done(done), .illegal(illegal), .fu_error(fu_error),
        .rs1_en(rs1_en), .rs2_en(rs2_en), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
        .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .add_lhs(add_lhs), .add_rhs(add_rhs), .add_op(add_op),
        .add_valid(add_valid), .add_result(add_result),
        .bit_lhs(bit_lhs), .bit_rhs(bit_rhs), .bit_op(bit_op),
        .bit_valid(bit_valid), .bit_result(bit_result),
        .shf_lhs(shf_lhs), .shf_rhs(shf_rhs), .shf_op(shf_op),
        .shf_valid(shf_valid), .shf_result(shf_result)
    );

    always #5 clk = ~clk;

    // GPR model: data appears the cycle after the enable
    always @(posedge clk) begin
        rs1_rdata <= rs1_en ? gpr[rs1_addr] : 32'hDEAD_BEEF;
        rs2_rdata <= rs2_en ? gpr[rs2_addr] : 32'hDEAD_BEEF;
    end

    // Functional-unit models
    always_comb begin
        case (add_op)
            2'b00:   add_result = {1'b0, add_lhs} + {1'b0, add_rhs};
            2'b01:   add_result = {1'b0, add_lhs} - {1'b0, add_rhs};
            default: add_result = 33'd0;
        endcase
        case (bit_op)
            2'b00:   bit_result = bit_lhs & bit_rhs;
            2'b01:   bit_result = bit_lhs | bit_rhs;
            2'b10:   bit_result = bit_lhs ^ bit_rhs;
            default: bit_result = 32'd0;
        endcase
        case (shf_op)
            2'b00:   shf_result = shf_lhs << shf_rhs[4:0];
            2'b01:   shf_result = shf_lhs >> shf_rhs[4:0];
            2'b10:   shf_result = $unsigned($signed(shf_lhs) >>> shf_rhs[4:0]);
            default: shf_result = 32'd0;
        endcase
    end

    assign add_valid = add_ven;
    assign bit_valid = bit_ven;
    assign shf_valid = shf_ven;

    // Issue one instruction and observe it until instr_ready returns.
    // Cycle 1 is the cycle after the accepting edge. At release_cyc all
    // FU valids are raised.
    task automatic run_instr(input logic [31:0] ins, input int release_cyc);
        cyc_done = -1; cyc_ill = -1; cyc_err = -1; cyc_ready = -1; wen_cnt = 0;
        rs1_seen = 1'b0; c1_rs1_en = 1'b0; c1_rs2_en = 1'b0;
        wb_addr = 5'd0; wb_data = 32'd0;
        cap_add_lhs = 32'd0; cap_add_rhs = 32'd0; cap_bit_lhs = 32'd0;
        cap_shf_lhs = 32'd0; cap_shf_rhs = 32'd0;
        cap_add_op = 2'd0; cap_bit_op = 2'd0; cap_shf_op = 2'd0;
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = 32'd0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                c1_rs1_en = rs1_en;
                c1_rs2_en = rs2_en;
            end
            if (c == 3) begin
                cap_add_lhs = add_lhs; cap_add_rhs = add_rhs; cap_add_op = add_op;
                cap_bit_lhs = bit_lhs; cap_bit_op = bit_op;
                cap_shf_lhs = shf_lhs; cap_shf_rhs = shf_rhs; cap_shf_op = shf_op;
            end
            if (rs1_en) rs1_seen = 1'b1;
            if (done && cyc_done < 0) cyc_done = c;
            if (illegal && cyc_ill < 0) cyc_ill = c;
            if (fu_error && cyc_err < 0) cyc_err = c;
            if (rd_wen) begin
                wen_cnt++;
                wb_addr = rd_addr;
                wb_data = rd_wdata;
            end
            if (c == release_cyc) begin
                add_ven = 1'b1; bit_ven = 1'b1; shf_ven = 1'b1;
            end
            if (instr_ready) begin
                cyc_ready = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
        checks++; if ({done, illegal, fu_error, rd_wen, rs1_en, rs2_en} !== 6'd0) begin fails++; $display("FAIL reset_pulses: got %b expected 000000", {done, illegal, fu_error, rd_wen, rs1_en, rs2_en}); end
        checks++; if ({rd_addr, rd_wdata, add_lhs, bit_lhs, shf_lhs} !== 133'd0) begin fails++; $display("FAIL reset_data: rd_addr %h rd_wdata %h expected 0", rd_addr, rd_wdata); end
        reset = 1'b0;
    endtask

    task automatic test_addi();
        run_instr(32'hFFF0_0293, -1);
        checks++; if (c1_rs1_en !== 1'b1 || c1_rs2_en !== 1'b0) begin fails++; $display("FAIL addi_read_en: got rs1 %b rs2 %b expected 1 0", c1_rs1_en, c1_rs2_en); end
        checks++; if (cap_add_lhs !== 32'd0 || cap_add_rhs !== 32'hFFFF_FFFF || cap_add_op !== 2'b00) begin fails++; $display("FAIL addi_fu: got %h %h %b expected 0 ffffffff 00", cap_add_lhs, cap_add_rhs, cap_add_op); end
        checks++; if (cyc_done !== 4) begin fails++; $display("FAIL addi_done_cycle: got %0d expected 4", cyc_done); end
        checks++; if (wen_cnt !== 1 || wb_addr !== 5'd5 || wb_data !== 32'hFFFF_FFFF) begin fails++; $display("FAIL addi_write: got n=%0d x%0d=%h expected 1 x5=ffffffff", wen_cnt, wb_addr, wb_data); end
        checks++; if (cyc_ready !== 5) begin fails++; $display("FAIL addi_ready_cycle: got %0d expected 5", cyc_ready); end
    endtask

    task automatic test_slt();
        gpr[1] = 32'hFFFF_FFFE; gpr[2] = 32'd1;
        run_instr(32'h0020_A1B3, -1);  // SLT x3,x1,x2
        checks++; if (c1_rs2_en !== 1'b1) begin fails++; $display("FAIL slt_rs2_en: got %b expected 1", c1_rs2_en); end
        checks++; if (cap_add_op !== 2'b01 || cap_add_lhs !== 32'hFFFF_FFFE || cap_add_rhs !== 32'd1) begin fails++; $display("FAIL slt_fu: got %b %h %h expected 01 fffffffe 1", cap_add_op, cap_add_lhs, cap_add_rhs); end
        checks++; if (cap_bit_lhs !== 32'd0 || cap_shf_lhs !== 32'd0) begin fails++; $display("FAIL slt_unselected_fu: got %h %h expected 0 0", cap_bit_lhs, cap_shf_lhs); end
        checks++; if (wen_cnt !== 1 || wb_addr !== 5'd3 || wb_data !== 32'd1) begin fails++; $display("FAIL slt_result: got n=%0d x%0d=%h expected 1 x3=1", wen_cnt, wb_addr, wb_data); end
        run_instr(32'h0020_B1B3, -1);  // SLTU x3,x1,x2
        checks++; if (wen_cnt !== 1 || wb_data !== 32'd0) begin fails++; $display("FAIL sltu_false: got n=%0d %h expected 1 0", wen_cnt, wb_data); end
        run_instr(32'h0011_31B3, -1);  // SLTU x3,x2,x1
        checks++; if (wb_data !== 32'd1) begin fails++; $display("FAIL sltu_true: got %h expected 1", wb_data); end
        run_instr(32'h0011_21B3, -1);  // SLT x3,x2,x1 : 1 < -2 is false
        checks++; if (wen_cnt !== 1 || wb_data !== 32'd0) begin fails++; $display("FAIL slt_false: got n=%0d %h expected 1 0", wen_cnt, wb_data); end
    endtask

    task automatic test_shift();
        gpr[1] = 32'h8000_0000;
        run_instr(32'h4040_D213, -1);  // SRAI x4,x1,4
        checks++; if (cap_shf_op !== 2'b10 || cap_shf_rhs !== 32'd4 || cap_shf_lhs !== 32'h8000_0000) begin fails++; $display("FAIL srai_fu: got %b %h %h expected 10 4 80000000", cap_shf_op, cap_shf_rhs, cap_shf_lhs); end
        checks++; if (wb_addr !== 5'd4 || wb_data !== 32'hF800_0000) begin fails++; $display("FAIL srai_result: got x%0d=%h expected x4=f8000000", wb_addr, wb_data); end
        gpr[1] = 32'd3; gpr[2] = 32'h0000_0124;
        run_instr(32'h0020_93B3, -1);  // SLL x7,x1,x2 uses only x2[4:0]=4
        checks++; if (cap_shf_op !== 2'b00 || cap_shf_rhs !== 32'd4) begin fails++; $display("FAIL sll_rhs: got %b %h expected 00 4", cap_shf_op, cap_shf_rhs); end
        checks++; if (wb_addr !== 5'd7 || wb_data !== 32'h30) begin fails++; $display("FAIL sll_result: got x%0d=%h expected x7=30", wb_addr, wb_data); end
    endtask

    task automatic test_illegal();
        run_instr(32'h0000_8283, -1);  // load opcode
        checks++; if (cyc_ill !== 1 || cyc_ready !== 2) begin fails++; $display("FAIL ill_opcode_timing: got ill %0d ready %0d expected 1 2", cyc_ill, cyc_ready); end
        checks++; if (rs1_seen !== 1'b0 || wen_cnt !== 0 || cyc_done !== -1) begin fails++; $display("FAIL ill_opcode_side: got rs1 %b wen %0d done %0d expected 0 0 -1", rs1_seen, wen_cnt, cyc_done); end
        run_instr(32'h0220_81B3, -1);  // ADD with funct7 0000001
        checks++; if (cyc_ill !== 1 || wen_cnt !== 0) begin fails++; $display("FAIL ill_funct7: got ill %0d wen %0d expected 1 0", cyc_ill, wen_cnt); end
        run_instr(32'h4040_9213, -1);  // SLLI with funct7 0100000
        checks++; if (cyc_ill !== 1) begin fails++; $display("FAIL ill_slli_f7: got %0d expected 1", cyc_ill); end
    endtask

    task automatic test_timeout();
        gpr[1] = 32'h0000_F0F0; gpr[2] = 32'h0000_0FF0;
        bit_ven = 1'b0;
        run_instr(32'h0020_C433, -1);  // XOR x8,x1,x2
        checks++; if (cap_bit_op !== 2'b10 || cap_add_lhs !== 32'd0) begin fails++; $display("FAIL tmo_fu_drive: got bit_op %b add_lhs %h expected 10 0", cap_bit_op, cap_add_lhs); end
        checks++; if (cyc_err !== 18) begin fails++; $display("FAIL tmo_err_cycle: got %0d expected 18", cyc_err); end
        checks++; if (wen_cnt !== 0 || cyc_done !== -1 || cyc_ready !== 19) begin fails++; $display("FAIL tmo_no_write: got wen %0d done %0d ready %0d expected 0 -1 19", wen_cnt, cyc_done, cyc_ready); end
        bit_ven = 1'b1;
        gpr[1] = 32'd5; gpr[2] = 32'd7;
        run_instr(32'h0020_81B3, -1);  // ADD x3,x1,x2
        checks++; if (cyc_done !== 4 || wb_addr !== 5'd3 || wb_data !== 32'd12) begin fails++; $display("FAIL tmo_recover_add: got done %0d x%0d=%h expected 4 x3=c", cyc_done, wb_addr, wb_data); end
        gpr[1] = 32'h0000_F0F0; gpr[2] = 32'h0000_0FF0;
        run_instr(32'h0020_C433, -1);
        checks++; if (wb_addr !== 5'd8 || wb_data !== 32'h0000_FF00) begin fails++; $display("FAIL xor_result: got x%0d=%h expected x8=ff00", wb_addr, wb_data); end
    endtask

    task automatic test_stall();
        gpr[1] = 32'd5; gpr[2] = 32'd7;
        add_ven = 1'b0;
        run_instr(32'h4020_81B3, 5);  // SUB x3,x1,x2, valid rises in cycle 5
        checks++; if (cap_add_op !== 2'b01) begin fails++; $display("FAIL stall_sub_op: got %b expected 01", cap_add_op); end
        checks++; if (cyc_done !== 6 || cyc_ready !== 7) begin fails++; $display("FAIL stall_latency: got done %0d ready %0d expected 6 7", cyc_done, cyc_ready); end
        checks++; if (wb_data !== 32'hFFFF_FFFE) begin fails++; $display("FAIL stall_result: got %h expected fffffffe", wb_data); end
    endtask

    task automatic test_reset_exec();
        int bad = 0;
        gpr[1] = 32'd5; gpr[2] = 32'd7;
        add_ven = 1'b0;
        @(negedge clk);
        instr = 32'h0020_81B3;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (add_lhs !== 32'd5 || add_rhs !== 32'd7) begin fails++; $display("FAIL rst_exec_inflight: got %h %h expected 5 7", add_lhs, add_rhs); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        add_ven = 1'b1;
        checks++; if (instr_ready !== 1'b1 || rd_wen !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rst_exec_idle: got ready %b wen %b done %b expected 1 0 0", instr_ready, rd_wen, done); end
        repeat (6) begin
            @(negedge clk);
            if (rd_wen || done) bad++;
        end
        checks++; if (bad !== 0) begin fails++; $display("FAIL rst_exec_dropped: got %0d retire cycles expected 0", bad); end
        run_instr(32'h0020_8033, -1);  // ADD x0,x1,x2
        checks++; if (cyc_done !== 4 || wen_cnt !== 0 || cyc_ready !== 5) begin fails++; $display("FAIL x0_write: got done %0d wen %0d ready %0d expected 4 0 5", cyc_done, wen_cnt, cyc_ready); end
    endtask

    initial begin
        reset = 1'b1;
        instr_valid = 1'b0;
        instr = 32'd0;
        add_ven = 1'b1; bit_ven = 1'b1; shf_ven = 1'b1;
        for (int i = 0; i < 32; i++) gpr[i] = 32'd0;
        test_reset();
        test_addi();
        test_slt();
        test_shift();
        test_illegal();
        test_timeout();
        test_stall();
        test_reset_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
